fwd_scoreboard_unit: RTL and testbench
======================================

// Module: fwd_scoreboard_unit
// PURPOSE
//  Parametrised forwarding/hazard unit for the 5-stage pipeline. Tracks destination tags of
//  in-flight instructions in a shift-register scoreboard (EX..WB), computes operand forward
//  selects in ID and registers them into EX, raises load-use stall, and handles load->store
//  data forwarding in MEM without a stall. Honors the cache-miss pipeline freeze (adv=0).
// PARAMETERS
//  REG_AW      4   register-address width (2**REG_AW architectural regs)
//  NUM_STAGES  3   tracked slots after ID: slot0=EX, slot1=MEM, ..., slot[NUM_STAGES-1]=WB (>=3)
//  SEL_W       $clog2(NUM_STAGES)  forward-select width; code k>0 = source slot k, 0 = reg file
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       synchronous reset, active low
//  adv          in   1       pipeline advance; 0 = global freeze (cache miss), all state holds
//  flush        in   1       squash ID instruction (branch redirect); it enters EX as bubble
//  id_valid     in   1       ID holds a real instruction
//  id_rd        in   REG_AW  ID destination reg;  id_wr in 1: ID writes id_rd
//  id_load      in   1       ID is a load;  id_store in 1: ID is a store (rs2 = store data)
//  id_rs1       in   REG_AW  source 1;  id_rs1_use in 1: rs1 read
//  id_rs2       in   REG_AW  source 2;  id_rs2_use in 1: rs2 read
//  id_alusrc    in   1       ALU operand B is immediate (rs2 not an ALU operand)
//  ex_fwd_a     out  SEL_W   EX ALU operand A select (registered)
//  ex_fwd_b     out  SEL_W   EX ALU operand B select (registered; 0 when id_alusrc was 1)
//  ex_fwd_c     out  SEL_W   EX store-data/rs2 select regardless of alusrc (registered)
//  mem_fwd_d    out  1       MEM store data taken from WB result (registered)
//  stall        out  1       load-use hazard: hold PC and IF/ID (combinational)
// BEHAVIOUR
//  - Slot fields: valid, rd, wr, load. "Producer k" = slot k valid & wr & rd==src.
//  - stall = id_valid & !flush & slot0.valid & slot0.load & slot0.wr & ((id_rs1_use & rd==id_rs1)
//    | (id_rs2_use & !id_store & rd==id_rs2)). Store-data-only dependence on a load: no stall.
//  - Select for src s: k = lowest index in 0..NUM_STAGES-2 with producer k matching s; registered
//    code = k+1 (slot k shifts to k+1 on the same edge); none -> 0. Youngest producer wins.
//    Slot NUM_STAGES-1 (WB) never forwarded: reg file is write-before-read.
//  - ex_fwd_c/ex_fwd_b from slot0 load match with id_store: code 0 at EX; mem_fwd_d set instead.
//  - mem_fwd_d registered on EX->MEM: EX instr is store and its rs2 matched a load producer then
//    in MEM (now WB). Module retains EX instr rs2/store flag internally for this.
//  - Edge priority: !rst_n > !adv > stall/flush > normal.
//    reset: all slots invalid, ex_fwd_a/b/c=0, mem_fwd_d=0; stall is 0 once slots invalid.
//    !adv: slots, selects, mem_fwd_d hold (freeze mid-miss is lossless); stall still evaluated.
//    adv & (stall|flush|!id_valid): slots shift, slot0 <= bubble, ex_fwd_* <= 0.
//    adv normal: slots shift, slot0 <= ID fields, ex_fwd_* <= computed codes.
//  - Oldest slot shifts out and is discarded. Reg 0 is an ordinary register unless macro below.
//  - Latency: selects valid in EX the cycle after ID evaluation; stall same cycle.
// CONFIGURATION
//  FWD_R0_ZERO_EN defined: reg 0 hardwired zero; any compare with rd==0 never matches
//    (no forward, no stall). Undefined: reg 0 treated like any other register.
// TESTING
//  1 ADD r3 then ADD r4=r3+r1 back-to-back, adv=1 -> ex_fwd_a=1 on consumer's EX cycle, stall=0.
//  2 r3 written by I0 and I1, then I2 reads r3 -> ex_fwd_a=1 (youngest I1), not 2.
//  3 LW r5 then ADD r6=r5+r2 -> stall=1 one cycle, bubble inserted, then ex_fwd_a=2.
//  4 LW r5 then SW r5 -> stall=0, ex_fwd_c=0, mem_fwd_d=1 in store's MEM cycle.
//  5 case 1 with adv=0 for 4 cycles mid-flight -> all outputs hold, resume identical to case 1.
//  6 rst_n=0 one edge with slots full -> all outputs 0; flush on ID producer -> no later forward.

Source files
------------

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit: in-flight destination scoreboard, registered EX forward selects,
// load-use stall and MEM load->store data forward. Optional macro FWD_R0_ZERO_EN makes reg 0 never match.
module fwd_scoreboard_unit #(
  parameter int REG_AW     = 4,
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = $clog2(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_store,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_use,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_use,
  input  logic              id_alusrc,
  output logic [SEL_W-1:0]  ex_fwd_a,
  output logic [SEL_W-1:0]  ex_fwd_b,
  output logic [SEL_W-1:0]  ex_fwd_c,
  output logic              mem_fwd_d,
  output logic              stall
);

  // The WB slot is never a forward source (write-before-read register file), so only
  // slots EX..NUM_STAGES-2 are physically held; the WB entry is the one shifted out.
  localparam int TRK = NUM_STAGES - 1;

  logic [TRK-1:0]    slot_vld_q, slot_vld_d;
  logic [TRK-1:0]    slot_wr_q, slot_wr_d;
  logic [TRK-1:0]    slot_ld_q, slot_ld_d;
  logic [REG_AW-1:0] slot_rd_q [TRK];
  logic [REG_AW-1:0] slot_rd_d [TRK];

  logic [SEL_W-1:0]  ex_fwd_a_q, ex_fwd_a_d;
  logic [SEL_W-1:0]  ex_fwd_b_q, ex_fwd_b_d;
  logic [SEL_W-1:0]  ex_fwd_c_q, ex_fwd_c_d;
  logic              mem_fwd_d_q, mem_fwd_d_d;

  logic              ex_store_q, ex_store_d;
  logic              ex_rs2_use_q, ex_rs2_use_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;

  logic [TRK-1:0]    hit_rs1, hit_rs2;
  logic              stall_c, bubble, st_ld0, mem_hit;
  logic [SEL_W-1:0]  code_a, code_b, code_c;

  function automatic logic prod_hit(input logic vld, input logic wr,
                                    input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] src);
`ifdef FWD_R0_ZERO_EN
    prod_hit = vld & wr & (rd == src) & (rd != '0);
`else
    prod_hit = vld & wr & (rd == src);
`endif
  endfunction

  // Lowest matching slot is the youngest producer; code is k+1 because the slot
  // advances one position on the same edge that loads the select into EX.
  function automatic logic [SEL_W-1:0] first_code(input logic [TRK-1:0] hit);
    first_code = '0;
    for (int k = TRK - 1; k >= 0; k--) begin
      if (hit[k]) first_code = SEL_W'(k + 1);
    end
  endfunction

  // ---- ID stage: hazard detection and select computation ----
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    for (int k = 0; k < TRK; k++) begin
      hit_rs1[k] = id_rs1_use & prod_hit(slot_vld_q[k], slot_wr_q[k], slot_rd_q[k], id_rs1);
      hit_rs2[k] = id_rs2_use & prod_hit(slot_vld_q[k], slot_wr_q[k], slot_rd_q[k], id_rs2);
    end
    stall_c = id_valid & ~flush & slot_ld_q[0] & (hit_rs1[0] | (hit_rs2[0] & ~id_store));
    bubble  = stall_c | flush | ~id_valid;
    // Store data from a load one ahead is patched in MEM instead of stalling.
    st_ld0  = id_store & hit_rs2[0] & slot_ld_q[0];
    code_a  = first_code(hit_rs1);
    code_c  = st_ld0 ? '0 : first_code(hit_rs2);
    code_b  = id_alusrc ? '0 : code_c;
    mem_hit = ex_store_q & ex_rs2_use_q & slot_ld_q[1] &
              prod_hit(slot_vld_q[1], slot_wr_q[1], slot_rd_q[1], ex_rs2_q);
  end

  // ---- ID->EX / EX->MEM boundary: next-state ----
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_wr_d    = slot_wr_q;
    slot_ld_d    = slot_ld_q;
    slot_rd_d    = slot_rd_q;
    ex_fwd_a_d   = ex_fwd_a_q;
    ex_fwd_b_d   = ex_fwd_b_q;
    ex_fwd_c_d   = ex_fwd_c_q;
    mem_fwd_d_d  = mem_fwd_d_q;
    ex_store_d   = ex_store_q;
    ex_rs2_use_d = ex_rs2_use_q;
    ex_rs2_d     = ex_rs2_q;
    if (adv) begin
      for (int k = 1; k < TRK; k++) begin
        slot_vld_d[k] = slot_vld_q[k-1];
        slot_wr_d[k]  = slot_wr_q[k-1];
        slot_ld_d[k]  = slot_ld_q[k-1];
        slot_rd_d[k]  = slot_rd_q[k-1];
      end
      slot_vld_d[0] = ~bubble;
      slot_wr_d[0]  = id_wr & ~bubble;
      slot_ld_d[0]  = id_load & ~bubble;
      slot_rd_d[0]  = id_rd;
      ex_fwd_a_d    = bubble ? '0 : code_a;
      ex_fwd_b_d    = bubble ? '0 : code_b;
      ex_fwd_c_d    = bubble ? '0 : code_c;
      mem_fwd_d_d   = mem_hit;
      ex_store_d    = id_store & ~bubble;
      ex_rs2_use_d  = id_rs2_use;
      ex_rs2_d      = id_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld_q  <= '0;
      ex_fwd_a_q  <= '0;
      ex_fwd_b_q  <= '0;
      ex_fwd_c_q  <= '0;
      mem_fwd_d_q <= 1'b0;
      ex_store_q  <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      ex_fwd_a_q  <= ex_fwd_a_d;
      ex_fwd_b_q  <= ex_fwd_b_d;
      ex_fwd_c_q  <= ex_fwd_c_d;
      mem_fwd_d_q <= mem_fwd_d_d;
      ex_store_q  <= ex_store_d;
    end
  end

  // Payload fields are qualified by the valid/store flags above, so they carry no reset.
  always_ff @(posedge clk) begin
    slot_wr_q    <= slot_wr_d;
    slot_ld_q    <= slot_ld_d;
    slot_rd_q    <= slot_rd_d;
    ex_rs2_use_q <= ex_rs2_use_d;
    ex_rs2_q     <= ex_rs2_d;
  end

  assign ex_fwd_a  = ex_fwd_a_q;
  assign ex_fwd_b  = ex_fwd_b_q;
  assign ex_fwd_c  = ex_fwd_c_q;
  assign mem_fwd_d = mem_fwd_d_q;
  assign stall     = stall_c;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: per-scenario instruction tables with
// hand-derived expected stall and registered selects, checked through an expectation queue.
module tb_fwd_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n, adv, flush, id_valid, id_wr, id_load, id_store;
  logic [3:0] id_rd, id_rs1, id_rs2;
  logic       id_rs1_use, id_rs2_use, id_alusrc;
  logic [1:0] ex_fwd_a, ex_fwd_b, ex_fwd_c;
  logic       mem_fwd_d, stall;

  always #5 clk = ~clk;

  fwd_scoreboard_unit #(.REG_AW(4), .NUM_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush), .id_valid(id_valid),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load), .id_store(id_store),
    .id_rs1(id_rs1), .id_rs1_use(id_rs1_use), .id_rs2(id_rs2), .id_rs2_use(id_rs2_use),
    .id_alusrc(id_alusrc), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_fwd_c(ex_fwd_c),
    .mem_fwd_d(mem_fwd_d), .stall(stall)
  );

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic       d;
  } exp_t;

  typedef struct {
    logic       v, wr, ld, st, u1, u2, alusrc, flush, adv, rstn;
    logic [3:0] rd, rs1, rs2;
    logic       exp_stall;
    exp_t       exp;
  } step_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef FWD_R0_ZERO_EN
  localparam int R0F = 0;
`else
  localparam int R0F = 1;
`endif

  function automatic step_t mk_nop();
    step_t s;
    s.v = 0; s.wr = 0; s.ld = 0; s.st = 0; s.u1 = 0; s.u2 = 0; s.alusrc = 0;
    s.flush = 0; s.adv = 1; s.rstn = 1; s.rd = 0; s.rs1 = 0; s.rs2 = 0;
    s.exp_stall = 0; s.exp = '0;
    return s;
  endfunction

  function automatic step_t mk_alu(input int rd, input int rs1, input int rs2);
    step_t s = mk_nop();
    s.v = 1; s.wr = 1; s.rd = 4'(rd); s.rs1 = 4'(rs1); s.u1 = 1; s.rs2 = 4'(rs2); s.u2 = 1;
    return s;
  endfunction

  function automatic step_t mk_lw(input int rd, input int base);
    step_t s = mk_nop();
    s.v = 1; s.wr = 1; s.ld = 1; s.rd = 4'(rd); s.rs1 = 4'(base); s.u1 = 1; s.alusrc = 1;
    return s;
  endfunction

  function automatic step_t mk_sw(input int base, input int data);
    step_t s = mk_nop();
    s.v = 1; s.st = 1; s.rs1 = 4'(base); s.u1 = 1; s.rs2 = 4'(data); s.u2 = 1; s.alusrc = 1;
    return s;
  endfunction

  function automatic step_t ex(input step_t s, input int st, input int a, input int b,
                               input int c, input int d);
    step_t r = s;
    r.exp_stall = 1'(st);
    r.exp = {2'(a), 2'(b), 2'(c), 1'(d)};
    return r;
  endfunction

  function automatic step_t frz(input step_t s);
    step_t r = s;
    r.adv = 0;
    return r;
  endfunction

  function automatic step_t fl(input step_t s);
    step_t r = s;
    r.flush = 1;
    return r;
  endfunction

  function automatic step_t rst(input step_t s);
    step_t r = s;
    r.rstn = 0;
    return r;
  endfunction

  task automatic drive(input step_t s);
    rst_n = s.rstn; adv = s.adv; flush = s.flush; id_valid = s.v;
    id_rd = s.rd; id_wr = s.wr; id_load = s.ld; id_store = s.st;
    id_rs1 = s.rs1; id_rs1_use = s.u1; id_rs2 = s.rs2; id_rs2_use = s.u2;
    id_alusrc = s.alusrc;
  endtask

  task automatic test_reset();
    step_t q[$];
    exp_t e, o;
    q.push_back(ex(rst(mk_nop()), 0, 0, 0, 0, 0));
    q.push_back(ex(rst(mk_nop()), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL reset[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL reset[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t q[$];
    exp_t e, o;
    q.push_back(ex(mk_alu(3, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(4, 3, 1), 0, 1, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(3, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(3, 4, 5), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 3, 7), 0, 1, 0, 0, 0));
    q.push_back(ex(mk_alu(7, 6, 3), 0, 1, 2, 2, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL b2b[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL b2b[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_distance();
    step_t q[$];
    step_t s;
    exp_t e, o;
    q.push_back(ex(mk_alu(8, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(9, 1, 8), 0, 0, 2, 2, 0));
    s = mk_alu(10, 8, 9); s.alusrc = 1;
    q.push_back(ex(s, 0, 0, 0, 1, 0));
    q.push_back(ex(mk_alu(0, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(11, 0, 0), 0, R0F, R0F, R0F, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL dist[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL dist[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_load_use_flush();
    step_t q[$];
    step_t s;
    exp_t e, o;
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 5, 2), 1, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 5, 2), 0, 2, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(7, 2, 5), 1, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(7, 2, 5), 0, 0, 2, 2, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(fl(mk_alu(6, 5, 2)), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(7, 5, 2), 0, 2, 0, 0, 0));
    q.push_back(ex(fl(mk_alu(3, 1, 2)), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(4, 3, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(4, 3, 3), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    s = mk_alu(6, 5, 2); s.v = 0;
    q.push_back(ex(s, 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL ldu[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL ldu[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_load_store();
    step_t q[$];
    exp_t e, o;
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_sw(2, 5), 0, 0, 0, 0, 0));
    q.push_back(ex(frz(mk_nop()), 0, 0, 0, 0, 0));
    q.push_back(ex(frz(mk_nop()), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 1));
    q.push_back(ex(frz(mk_nop()), 0, 0, 0, 0, 1));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(7, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_sw(3, 7), 0, 0, 0, 1, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_sw(2, 5), 0, 0, 0, 2, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL ldst[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL ldst[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_freeze();
    step_t q[$];
    exp_t e, o;
    q.push_back(ex(mk_alu(3, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(4, 3, 1), 0, 1, 0, 0, 0));
    for (int k = 0; k < 4; k++) q.push_back(ex(frz(mk_alu(5, 3, 4)), 0, 1, 0, 0, 0));
    q.push_back(ex(mk_alu(5, 3, 4), 0, 2, 1, 1, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(frz(mk_alu(6, 5, 2)), 1, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 5, 2), 1, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 5, 2), 0, 2, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL frz[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL frz[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  task automatic test_reset_full();
    step_t q[$];
    exp_t e, o;
    q.push_back(ex(mk_alu(3, 1, 2), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 3), 0, 1, 0, 0, 0));
    q.push_back(ex(rst(mk_alu(6, 5, 3)), 1, 0, 0, 0, 0));
    q.push_back(ex(mk_alu(6, 5, 3), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_lw(5, 1), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_sw(2, 5), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 1));
    q.push_back(ex(rst(frz(mk_nop())), 0, 0, 0, 0, 0));
    q.push_back(ex(mk_nop(), 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      drive(q[i]); #2;
      n_cmp++;
      if (stall !== q[i].exp_stall) begin
        n_bad++; $display("FAIL rstf[%0d] stall got %b want %b", i, stall, q[i].exp_stall);
      end
      exp_q.push_back(q[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = {ex_fwd_a, ex_fwd_b, ex_fwd_c, mem_fwd_d};
      n_cmp++;
      if (o !== e) begin
        n_bad++; $display("FAIL rstf[%0d] a/b/c/d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                          i, o.a, o.b, o.c, o.d, e.a, e.b, e.c, e.d);
      end
    end
  endtask

  initial begin
    drive(rst(mk_nop()));
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use_flush();
    test_load_store();
    test_freeze();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
